// File: rtl/pwm_gen_pkg.sv
// Shared constants and helpers for the pwm_gen block.
package pwm_gen_pkg;

    // Default width of the duty code and period counter.
    localparam int PWM_WIDTH_DEFAULT = 4;

    // Number of clock cycles in one PWM period for a given counter width.
    function automatic int pwm_period(input int width);
        return 1 << width;
    endfunction

endpackage

// File: rtl/pwm_gen_counter.sv
// Free-running wrapping period counter for pwm_gen.
// Exposes the value the counter will take on the next edge and a flag
// marking the last cycle of a period (the edge where it wraps to zero).
module pwm_gen_counter
    import pwm_gen_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] cnt_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(pwm_period(WIDTH) - 1);

    logic [WIDTH-1:0] cnt;

    // Increment modulo 2**WIDTH; the natural overflow provides the wrap.
    assign cnt_next = cnt + WIDTH'(1);
    assign wrap     = (cnt == CNT_MAX);

    // Counter register, cleared asynchronously so a period restarts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// Fixed-period pulse-width modulator.
// The duty code x is latched only when the period counter wraps, so z is
// glitch-free within a period. z is registered and aligned with the counter.
// Optional feature: define PWM_GEN_SYNC_OUT_EN to add a registered
// period_start pulse that marks the first cycle of every period.
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    output logic             z
`ifdef PWM_GEN_SYNC_OUT_EN
    ,
    output logic             period_start
`endif
);

    logic [WIDTH-1:0] cnt_next;
    logic             wrap;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_next;

    pwm_gen_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .cnt_next (cnt_next),
        .wrap     (wrap)
    );

    // A new duty code only takes effect on the edge that starts a period.
    assign duty_next = wrap ? x : duty_q;

    // Duty latch and output; z uses next-state values so it lines up with cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
            z      <= 1'b0;
        end else begin
            duty_q <= duty_next;
            z      <= (cnt_next < duty_next);
        end
    end

`ifdef PWM_GEN_SYNC_OUT_EN
    // One-cycle marker for the cycle where cnt is zero after a wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking testbench for pwm_gen.
// Reference model: elapsed-cycle count since reset plus the duty value
// captured at each period boundary; z is expected high for the first
// duty cycles of each period. Honours PWM_GEN_SYNC_OUT_EN.
module tb_pwm_gen;

    localparam int WIDTH  = 4;
    localparam int PERIOD = 1 << WIDTH;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] x;
    logic             z;
`ifdef PWM_GEN_SYNC_OUT_EN
    logic             period_start;
`endif

    int n_checks;
    int n_fail;

    pwm_gen #(
        .WIDTH(WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z)
`ifdef PWM_GEN_SYNC_OUT_EN
        ,
        .period_start (period_start)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: t counts clock edges since reset release, and the
    // duty applied during a period is the x seen at the edge that began it.
    int         t;
    int         m_duty;
    logic       exp_z;
    logic       exp_ps;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t      <= 0;
            m_duty <= 0;
        end else begin
            if ((t % PERIOD) == PERIOD - 1) m_duty <= int'(x);
            t <= t + 1;
        end
    end

    assign exp_z  = ((t % PERIOD) < m_duty);
    assign exp_ps = ((t % PERIOD) == 0) && (t != 0);

    // Advance to the next negedge at which a new period has begun.
    task automatic align(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            if ((t % PERIOD) == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Observe one full period starting at cnt==0; gather high count,
    // model disagreements and any high cycle following a low one.
    task automatic measure_period(output int highs, output int bad, output int glitch);
        bit seen_low;
        highs    = 0;
        bad      = 0;
        glitch   = 0;
        seen_low = 1'b0;
        for (int i = 0; i < PERIOD; i++) begin
            if (z !== exp_z) bad++;
`ifdef PWM_GEN_SYNC_OUT_EN
            if (period_start !== exp_ps) bad++;
`endif
            if (z === 1'b1) begin
                highs++;
                if (seen_low) glitch++;
            end else begin
                seen_low = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] first_x;
        rst = 1'b1;
        x   = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (z !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_hold z=%b expected 0", z);
        end
`ifdef PWM_GEN_SYNC_OUT_EN
        n_checks++;
        if (period_start !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_hold period_start=%b expected 0", period_start);
        end
`endif
        rst     = 1'b0;
        first_x = WIDTH'($urandom_range(1, PERIOD - 1));
        x       = first_x;
        for (int i = 0; i < PERIOD; i++) begin
            n_checks++;
            if (z !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL first_period cycle=%0d z=%b expected 0", i, z);
            end
            @(negedge clk);
        end
        n_checks++;
        if (z !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL first_sample x=%0d z=%b expected 1", first_x, z);
        end
    endtask

    task automatic test_duty_one();
        bit ok;
        int highs, bad, glitch;
        x = WIDTH'(1);
        align(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL duty_one_align timeout");
            return;
        end
        for (int p = 0; p < 3; p++) begin
            measure_period(highs, bad, glitch);
            n_checks++;
            if (highs !== 1 || bad !== 0 || glitch !== 0) begin
                n_fail++;
                $display("[TB] FAIL duty_one period=%0d highs=%0d expected 1 model_diff=%0d glitch=%0d",
                         p, highs, bad, glitch);
            end
        end
    endtask

    task automatic test_duty_change();
        bit ok;
        int highs, bad, glitch;
        x = WIDTH'(5);
        align(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL duty_change_align timeout");
            return;
        end
        for (int p = 0; p < 2; p++) begin
            measure_period(highs, bad, glitch);
            n_checks++;
            if (highs !== 5 || bad !== 0) begin
                n_fail++;
                $display("[TB] FAIL duty_five period=%0d highs=%0d expected 5 model_diff=%0d", p, highs, bad);
            end
        end
        highs = 0;
        bad   = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i == 3) x = WIDTH'(9);
            if (z !== exp_z) bad++;
            if (z === 1'b1) highs++;
            @(negedge clk);
        end
        n_checks++;
        if (highs !== 5 || bad !== 0) begin
            n_fail++;
            $display("[TB] FAIL duty_change_current highs=%0d expected 5 model_diff=%0d", highs, bad);
        end
        measure_period(highs, bad, glitch);
        n_checks++;
        if (highs !== 9 || bad !== 0 || glitch !== 0) begin
            n_fail++;
            $display("[TB] FAIL duty_change_next highs=%0d expected 9 model_diff=%0d glitch=%0d",
                     highs, bad, glitch);
        end
    endtask

    task automatic test_extremes();
        bit ok;
        int highs, bad, glitch;
        int vals[2] = '{0, PERIOD - 1};
        foreach (vals[k]) begin
            x = WIDTH'(vals[k]);
            align(ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("[TB] FAIL extremes_align timeout value=%0d", vals[k]);
                return;
            end
            for (int p = 0; p < 4; p++) begin
                measure_period(highs, bad, glitch);
                n_checks++;
                if (highs !== vals[k] || bad !== 0 || glitch !== 0) begin
                    n_fail++;
                    $display("[TB] FAIL extreme value=%0d period=%0d highs=%0d model_diff=%0d glitch=%0d",
                             vals[k], p, highs, bad, glitch);
                end
            end
        end
    endtask

    task automatic test_sweep();
        bit ok;
        int highs, bad, glitch;
        for (int v = 0; v < PERIOD; v++) begin
            x = WIDTH'(v);
            align(ok);
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL sweep_align timeout value=%0d", v);
                return;
            end
            for (int p = 0; p < 2; p++) begin
                measure_period(highs, bad, glitch);
                n_checks++;
                if (highs !== v || bad !== 0 || glitch !== 0) begin
                    n_fail++;
                    $display("[TB] FAIL sweep value=%0d period=%0d highs=%0d model_diff=%0d glitch=%0d",
                             v, p, highs, bad, glitch);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) x = WIDTH'($urandom_range(0, PERIOD - 1));
            n_checks++;
            if (z !== exp_z) begin
                n_fail++;
                $display("[TB] FAIL random cycle=%0d z=%b expected %b", i, z, exp_z);
            end
`ifdef PWM_GEN_SYNC_OUT_EN
            n_checks++;
            if (period_start !== exp_ps) begin
                n_fail++;
                $display("[TB] FAIL random_sync cycle=%0d period_start=%b expected %b",
                         i, period_start, exp_ps);
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        x = WIDTH'(12);
        align(ok);
        align(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_align timeout");
            return;
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (z !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_pre z=%b expected 1", z);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (z !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_async z=%b expected 0", z);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < PERIOD; i++) begin
            n_checks++;
            if (z !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL mid_reset_restart cycle=%0d z=%b expected 0", i, z);
            end
            @(negedge clk);
        end
        n_checks++;
        if (z !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_resume z=%b expected 1", z);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        x        = '0;
        test_reset();
        test_duty_one();
        test_duty_change();
        test_extremes();
        test_sweep();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Fixed-period pulse-width modulator.
- A free-running WIDTH-bit counter sets the period, and a duty-cycle code on `x` sets how many cycles per period output `z` is high.
- Duty is sampled only at period boundaries, so `z` never glitches mid-period.
- Used as a leaf block driving LEDs, motor or analog-filter outputs from a small control word.

Parameters:
- WIDTH, 4, bit width of the duty code and the period counter; period = 2**WIDTH clock cycles (16 by default).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- x  input  WIDTH  duty code; number of high cycles per period (0 .. 2**WIDTH-1).
- z  output  1  PWM output, registered.

Behaviour:
- Clock and reset: one clock domain (`clk`). `rst` is asynchronous, active-high; all flops clear on assertion and stay clear while it is high.
- Reset values: cnt=0, duty_q=0, z=0.
- Counter: cnt increments by 1 every clock and wraps from 2**WIDTH-1 to 0. Wrap is unsigned modulo 2**WIDTH, with no terminal stall.
- Duty latch: duty_q <= x on the same edge where cnt wraps (cnt==2**WIDTH-1 -> 0).
  - `x` changes at any other time have no effect until the next wrap.
  - An X/undriven `x` is don't-care until the wrap edge.
- Output: z is registered and updated on the same edge as cnt/duty_q. It is computed from their next values: z = (cnt < duty_q), unsigned compare, so z is cycle-aligned with cnt.
- Period start: a new period begins whenever cnt==0.
  - z is high for cnt = 0 .. duty_q-1, low for cnt = duty_q .. 2**WIDTH-1.
- Boundaries:
  - duty_q=0: z constantly 0.
  - duty_q=2**WIDTH-1: z high 15 of 16 cycles (max 15/16 with default WIDTH); 100% duty is not reachable by design.
- First period after reset release: runs with duty_q=0 (z=0 for 16 cycles). The first `x` is sampled at the end of that period.
- Reset mid-period: immediate return to reset values; z drops asynchronously. The period restarts at cnt=0 after release.
- No combinational path from `x` to `z`.

Optional Feature:
- Macro: PWM_GEN_SYNC_OUT_EN.
- Defined: adds output `period_start` (1 bit, registered, reset 0). It is high for exactly one cycle whenever cnt==0, i.e. the cycle in which the newly latched duty_q takes effect. It is aligned with z.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package pwm_gen_pkg: constant PWM_WIDTH_DEFAULT=4; function or constant for PERIOD = 2**WIDTH.
- Sub-module pwm_gen_counter: WIDTH-bit wrapping counter with async reset, providing cnt and a wrap flag.
- Top pwm_gen holds the duty latch, comparator and optional sync output.

Test Plan:
- Reset: assert rst with clk running, then mid-period assert again -> z=0 immediately, cnt restarts at 0; first 16 cycles after release z=0 regardless of x.
- Duty 1: x=1 held -> from the first period after the wrap, z high 1 cycle, low 15, repeating; measured duty 1/16.
- Duty change mid-period: x=5 for several periods, then x=9 applied at cnt=3 -> current period keeps 5 high cycles; next period shows 9 high cycles.
- Extremes: x=0 -> z stuck 0 across 4 periods; x=15 -> z high 15, low 1 per period.
- Sweep: x=0..15, each held 2 periods -> high-cycle count per period equals the value latched at the preceding wrap; no mid-period glitches.
- PWM_GEN_SYNC_OUT_EN defined -> period_start pulses once every 16 cycles, coincident with the first cycle of each period; undefined build compiles and passes all of the above.
